// File: rtl/seq_alu_if.sv
// Operand/result bundle between a requester and the sequential ALU.
// Start is sampled only while Busy is low; Done pulses for one cycle when ALUout/CO/Z change.
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();
  logic             Start;
  logic [2:0]       InsSel;
  logic [WIDTH-1:0] ALUinA;
  logic [WIDTH-1:0] ALUinB;
  logic [WIDTH-1:0] ALUout;
  logic             CO;
  logic             Z;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, InsSel, ALUinA, ALUinB,
    input  ALUout, CO, Z, Busy, Done
  );

  modport slave (
    input  Start, InsSel, ALUinA, ALUinB,
    output ALUout, CO, Z, Busy, Done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts and a shift-add multiplier.
// Results and flags are registered and change only on the edge that raises Done.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_alu_if.slave     bus,
  output logic         dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               co_q, co_d;
  logic               z_q, z_d;
  logic               done_q, done_d;

  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_co;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [CNTW-1:0]    shamt;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign diff     = {1'b0, a_q} - {1'b0, b_q};
  assign prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);

  // Shift distances of WIDTH or more behave exactly like a WIDTH-bit shift.
  assign shamt = (32'(bus.ALUinB) >= 32'(WIDTH)) ? CNTW'(WIDTH) : CNTW'(bus.ALUinB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      co_q    <= co_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    res_d   = res_q;
    co_d    = co_q;
    z_d     = z_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    fin_res = '0;
    fin_co  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = EXEC;
          op_d    = bus.InsSel;
          a_d     = bus.ALUinA;
          b_d     = bus.ALUinB;
          mcand_d = {{WIDTH{1'b0}}, bus.ALUinA};
          prod_d  = '0;
          cnt_d   = (bus.InsSel == OP_SHL || bus.InsSel == OP_SHR) ? shamt : '0;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin fin = 1'b1; fin_res = sum[WIDTH-1:0];  fin_co = sum[WIDTH];  end
          OP_SUB: begin fin = 1'b1; fin_res = diff[WIDTH-1:0]; fin_co = diff[WIDTH]; end
          OP_AND: begin fin = 1'b1; fin_res = a_q & b_q; end
          OP_OR:  begin fin = 1'b1; fin_res = a_q | b_q; end
          OP_XOR: begin fin = 1'b1; fin_res = a_q ^ b_q; end
          OP_SHL, OP_SHR: begin
            // cnt_q holds the bits still to shift; a zero count finishes unchanged.
            if (cnt_q == '0) begin
              fin     = 1'b1;
              fin_res = a_q;
            end else begin
              a_d   = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
              cnt_d = cnt_q - CNTW'(1);
              if (cnt_q == CNTW'(1)) begin
                fin     = 1'b1;
                fin_res = a_d;
                fin_co  = (op_q == OP_SHL) ? a_q[WIDTH-1] : a_q[0];
              end
            end
          end
          default: begin
            prod_d  = prod_nxt;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              fin     = 1'b1;
              fin_res = prod_nxt[WIDTH-1:0];
              fin_co  = |prod_nxt[2*WIDTH-1:WIDTH];
            end
          end
        endcase
        if (fin) begin
          state_d = IDLE;
          res_d   = fin_res;
          co_d    = fin_co;
          z_d     = (fin_res == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ALUout  = res_q;
  assign bus.CO      = co_q;
  assign bus.Z       = z_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = (state_q == EXEC);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised scoreboard bench for seq_alu at WIDTH=8: driver pushes expected results,
// a monitor pops them on every Done pulse and checks result, flags and timing.
module tb_seq_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W), .CNTW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int unsigned accept_cyc);
    exp_t e;
    longint p;
    longint ia = longint'(a);
    longint ib = longint'(b);
    int n = (b >= W) ? W : int'(b);
    int lat = 1;
    logic co = 1'b0;
    case (op)
      3'd0: begin p = ia + ib; co = (p >= 256); end
      3'd1: begin p = (256 + ia - ib) % 256; co = (ia < ib); end
      3'd2: p = ia & ib;
      3'd3: p = ia | ib;
      3'd4: p = ia ^ ib;
      3'd5: begin
        p = ia << n;
        co = (n == 0) ? 1'b0 : ((p >> W) & 1) != 0;
        lat = (n == 0) ? 1 : n;
      end
      3'd6: begin
        p = ia >> n;
        co = (n == 0) ? 1'b0 : ((ia >> (n - 1)) & 1) != 0;
        lat = (n == 0) ? 1 : n;
      end
      default: begin p = ia * ib; co = (p >= 256); lat = W; end
    endcase
    e.res = W'(p % 256);
    e.co  = co;
    e.z   = (p % 256) == 0;
    e.cyc = accept_cyc + lat;
    return e;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (bus.Busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: Busy still high after %0d cycles, expected low", guard);
    end
    bus.Start  = 1'b1;
    bus.InsSel = op;
    bus.ALUinA = a;
    bus.ALUinB = b;
    exp_q.push_back(model(op, a, b, cyc + 1));
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.InsSel = 3'($urandom);
    bus.ALUinA = W'($urandom);
    bus.ALUinB = W'($urandom);
    check("busy_after_accept", 32'(bus.Busy), 32'd1);
    check("state_after_accept", 32'(dbg_state), 32'd1);
  endtask

  task automatic poke();
    if (bus.Busy === 1'b1) begin
      bus.Start  = 1'b1;
      bus.InsSel = 3'($urandom);
      bus.ALUinA = W'($urandom);
      bus.ALUinB = W'($urandom);
      @(negedge clk);
      bus.Start = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    logic [W+1:0] last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        last = '0;
        check("done_in_reset", 32'(bus.Done), 32'd0);
        check("out_in_reset", 32'({bus.ALUout, bus.CO, bus.Z}), 32'd0);
      end else if (bus.Done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: Done high with res 0x%0h, expected no Done", bus.ALUout);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(bus.ALUout), 32'(e.res));
          check("co", 32'(bus.CO), 32'(e.co));
          check("z", 32'(bus.Z), 32'(e.z));
          check("done_cycle", cyc, e.cyc);
          check("busy_in_done", 32'(bus.Busy), 32'd0);
        end
        last = {bus.ALUout, bus.CO, bus.Z};
      end else begin
        check("outputs_hold", 32'({bus.ALUout, bus.CO, bus.Z}), 32'(last));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.InsSel = '0;
    bus.ALUinA = '0;
    bus.ALUinB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_outputs", 32'({bus.ALUout, bus.CO, bus.Z}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(3'd0, 8'd200, 8'd100);
    issue(3'd1, 8'd5, 8'd5);
    issue(3'd1, 8'd3, 8'd5);
    issue(3'd7, 8'd16, 8'd16);
    issue(3'd7, 8'd15, 8'd17);
    issue(3'd5, 8'h81, 8'd1);
    issue(3'd6, 8'h81, 8'd9);
    issue(3'd5, 8'h81, 8'd0);
    issue(3'd6, 8'hF0, 8'd8);
    issue(3'd5, 8'h01, 8'd7);

    // Start during a multiply is ignored; next op goes back-to-back
    issue(3'd7, 8'd13, 8'd11);
    poke();
    poke();
    poke();
    issue(3'd0, 8'd1, 8'd2);

    // reset in the middle of a multiply
    issue(3'd7, 8'd200, 8'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_back());
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_outputs", 32'({bus.ALUout, bus.CO, bus.Z}), 32'd0);
    rst = 1'b0;
    issue(3'd4, 8'hA5, 8'h5A);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [W-1:0] b = (op == 3'd5 || op == 3'd6) ? W'($urandom_range(0, 12)) : W'($urandom);
      issue(op, W'($urandom), b);
      if ($urandom_range(0, 3) == 0) poke();
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 Parameter CNTW, default 4, width of the internal cycle counter; SHALL satisfy 2^CNTW > WIDTH.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Start  input  1  request a new operation; sampled only while the block is idle.
REQ-006 InsSel  input  3  operation select, latched with Start.
REQ-007 ALUinA  input  WIDTH  operand A, latched with Start.
REQ-008 ALUinB  input  WIDTH  operand B, latched with Start.
REQ-009 ALUout  output  WIDTH  registered result; holds its value between operations.
REQ-010 CO  output  1  registered carry/borrow/overflow flag.
REQ-011 Z  output  1  registered zero flag.
REQ-012 Busy  output  1  high while an operation is executing.
REQ-013 Done  output  1  one-cycle pulse marking that ALUout/CO/Z were just updated.

Function
REQ-014 FSM SHALL have states IDLE and EXEC; IDLE->EXEC on Start=1; EXEC->IDLE when the operation completes.
REQ-015 Busy SHALL be 1 exactly in EXEC; Start received in EXEC SHALL be ignored, with no latching and no effect on the running operation.
REQ-016 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B, 110 SHR (logical) A by B, 111 MUL (unsigned shift-add, low WIDTH bits).
REQ-017 Latency from the Start-accept edge to the Done pulse: 1 cycle for opcodes 000-100; max(1, min(B, WIDTH)) cycles for SHL/SHR, one bit per cycle; WIDTH cycles for MUL, one partial product per cycle.
REQ-018 ALUout, CO and Z SHALL update only on the edge that raises Done, and SHALL hold otherwise.
REQ-019 CO rules: ADD carry out of bit WIDTH-1; SUB 1 iff A<B unsigned (borrow); logic ops 0; SHL/SHR last bit shifted out (0 if count 0); MUL 1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero.
REQ-020 Z SHALL be 1 iff the new ALUout equals 0.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-022 Shift count B >= WIDTH SHALL saturate to WIDTH and produce result 0; CO is the last bit shifted out.
REQ-023 Shift count 0 SHALL produce result A and CO=0 in 1 cycle.
REQ-024 The Done cycle is in IDLE; Start asserted in that cycle SHALL be accepted, giving back-to-back operations with no gap.
REQ-025 Operand or InsSel changes during EXEC SHALL NOT affect the result.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE; ALUout=0, CO=0, Z=0, Busy=0, Done=0; counter and latched operands cleared.
REQ-027 rst SHALL take priority over Start and over any in-flight operation; an aborted operation SHALL NOT raise Done.

Verification (WIDTH=8)
REQ-028 ADD A=200 B=100 -> ALUout=44, CO=1, Z=0; Done 1 cycle after Start; Busy high for 1 cycle.
REQ-029 SUB A=5 B=5 -> ALUout=0, Z=1, CO=0; SUB A=3 B=5 -> ALUout=254, CO=1, Z=0.
REQ-030 MUL A=16 B=16 -> ALUout=0x00, CO=1, Z=1, Done exactly 8 cycles after Start; MUL A=15 B=17 -> 0xFF, CO=0.
REQ-031 SHL A=0x81 B=1 -> 0x02, CO=1 after 1 cycle; SHR A=0x81 B=9 -> 0x00, CO=1 after 8 cycles; SHL B=0 -> 0x81, CO=0.
REQ-032 Start pulsed with new operands mid-MUL -> ignored, original MUL result delivered; then Start in the Done cycle -> accepted back-to-back.
REQ-033 rst asserted on cycle 4 of a MUL -> all outputs 0 on the next edge, no Done pulse, block idle and accepting Start.
